instr_load_controller: RTL

Boot-time sequencer for the instruction fetch stage. Receives a length-prefixed program image as a byte stream from the UART receiver and packs it into little-endian 32-bit words. Writes those words into instruction memory through the fetch stage's write port (`write_byte_address`, `write_instr_data`, `write_instr_valid`), then raises `start` to release the core. Sits between the UART RX and the fetch stage; owns `start` for the whole core.

---
 rtl/instr_load_controller.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/instr_load_controller.sv
// instr_load_controller
// Boot-time loader: receives a length-prefixed program image byte stream
// (4-byte little-endian length N, then N payload bytes), packs it into
// little-endian 32-bit words, writes them to instruction memory, then
// raises start to release the core.
//
// Optional feature macro: LOADER_HALT_APPEND_EN
//   defined   -> a halt word 0xFFFFFFFF is written after the payload and the
//                length limit becomes MAX_BYTES-4
//   undefined -> no halt word; limit is MAX_BYTES
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data, rx_valid        UART RX byte and one-cycle strobe
//   reload                   drop start and wait for a new image
//   write_byte_address       word-aligned byte address of the write
//   write_instr_data         packed instruction word
//   write_instr_valid        one-cycle write strobe
//   start                    core run enable
//   busy                     high while a load is in progress
//   error                    sticky overflow/timeout flag
module instr_load_controller #(
  parameter int unsigned MAX_BYTES      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        reload,
  output logic [31:0] write_byte_address,
  output logic [31:0] write_instr_data,
  output logic        write_instr_valid,
  output logic        start,
  output logic        busy,
  output logic        error
);

  localparam int unsigned W = 32;
`ifdef LOADER_HALT_APPEND_EN
  localparam logic         HALT_EN = 1'b1;
  localparam logic [W-1:0] LIMIT   = W'(MAX_BYTES - 4);
`else
  localparam logic         HALT_EN = 1'b0;
  localparam logic [W-1:0] LIMIT   = W'(MAX_BYTES);
`endif
  localparam logic [W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_FLUSH, S_HALT, S_RUN
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] len_q, len_d;
  logic [1:0]   len_cnt_q, len_cnt_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] word_q, word_d;
  logic [W-1:0] timer_q, timer_d;
  logic [W-1:0] waddr_d, wdata_d;
  logic         wvalid_d, start_d, busy_d, error_d;

  logic [W-1:0] len_shift, word_ins, halt_addr;
  logic         last_byte, word_full, take_data;

  // Byte-lane insertion and end-of-word detection for the next payload byte
  always_comb begin
    len_shift = {rx_data, len_q[W-1:8]};
    word_ins  = word_q | (W'(rx_data) << {count_q[1:0], 3'b000});
    last_byte = (count_q + 32'd1) == len_q;
    word_full = (count_q[1:0] == 2'd3) || last_byte;
    halt_addr = (len_q + 32'd3) & ~32'd3;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    len_cnt_d = len_cnt_q;
    count_d   = count_q;
    word_d    = word_q;
    timer_d   = timer_q;
    waddr_d   = write_byte_address;
    wdata_d   = write_instr_data;
    wvalid_d  = 1'b0;
    start_d   = start;
    error_d   = error;
    take_data = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          len_d     = {rx_data, 24'h0};
          len_cnt_d = 2'd1;
          error_d   = 1'b0;
          timer_d   = '0;
          state_d   = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          timer_d   = '0;
          len_d     = len_shift;
          len_cnt_d = len_cnt_q + 2'd1;
          if (len_cnt_q == 2'd3) begin
            count_d = '0;
            word_d  = '0;
            if (len_shift > LIMIT) begin
              error_d = 1'b1;
              state_d = S_IDLE;
            end else if (len_shift == '0) begin
              if (HALT_EN) begin
                wvalid_d = 1'b1;
                waddr_d  = '0;
                wdata_d  = HALT_WORD;
                state_d  = S_HALT;
              end else begin
                start_d = 1'b1;
                state_d = S_RUN;
              end
            end else begin
              state_d = S_DATA;
            end
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_DATA: begin
        if (rx_valid) take_data = 1'b1;
        else          timer_d   = timer_q + 32'd1;
      end
      S_FLUSH: begin
        if (count_q == len_q) begin
          if (HALT_EN) begin
            wvalid_d = 1'b1;
            waddr_d  = halt_addr;
            wdata_d  = HALT_WORD;
            state_d  = S_HALT;
          end else begin
            start_d = 1'b1;
            state_d = S_RUN;
          end
        end else begin
          // A byte arriving alongside the write starts the next word
          state_d = S_DATA;
          if (rx_valid) take_data = 1'b1;
        end
      end
      S_HALT: begin
        start_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: ;
      default: state_d = S_IDLE;
    endcase

    // Payload byte: drop into its lane, write out when the word completes
    if (take_data) begin
      timer_d = '0;
      count_d = count_q + 32'd1;
      if (word_full) begin
        wvalid_d = 1'b1;
        waddr_d  = {count_q[W-1:2], 2'b00};
        wdata_d  = word_ins;
        word_d   = '0;
        state_d  = S_FLUSH;
      end else begin
        word_d = word_ins;
      end
    end

    // Inter-byte idle limit while a load is in progress
    if ((state_q == S_LEN || state_q == S_DATA) && timer_d == W'(TIMEOUT_CYCLES)) begin
      error_d = 1'b1;
      timer_d = '0;
      state_d = S_IDLE;
    end

    // reload overrides everything, including a byte arriving this cycle
    if (reload) begin
      state_d  = S_IDLE;
      start_d  = 1'b0;
      error_d  = 1'b0;
      wvalid_d = 1'b0;
      word_d   = '0;
      timer_d  = '0;
    end

    busy_d = (state_d == S_LEN) || (state_d == S_DATA) ||
             (state_d == S_FLUSH) || (state_d == S_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      len_q              <= '0;
      len_cnt_q          <= '0;
      count_q            <= '0;
      word_q             <= '0;
      timer_q            <= '0;
      write_byte_address <= '0;
      write_instr_data   <= '0;
      write_instr_valid  <= 1'b0;
      start              <= 1'b0;
      busy               <= 1'b0;
      error              <= 1'b0;
    end else begin
      state_q            <= state_d;
      len_q              <= len_d;
      len_cnt_q          <= len_cnt_d;
      count_q            <= count_d;
      word_q             <= word_d;
      timer_q            <= timer_d;
      write_byte_address <= waddr_d;
      write_instr_data   <= wdata_d;
      write_instr_valid  <= wvalid_d;
      start              <= start_d;
      busy               <= busy_d;
      error              <= error_d;
    end
  end

endmodule
